// File: rtl/axi_stream_burst_writer_if.sv
// AXI4 bundle (write address, write data, write response, read address,
// read data) between the burst writer and an AXI slave.
//   master : burst writer side (drives AW/W/AR request fields, B/R ready)
//   slave  : AXI slave side (drives awready/wready/arready, bvalid, rvalid/rdata)
interface axi_stream_burst_writer_if;
  logic [15:0] awaddr;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bready;
  logic        bvalid;
  logic [15:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output awaddr, awburst, awlen, awsize, awvalid,
    output wdata, wstrb, wvalid, bready,
    output araddr, arburst, arlen, arsize, arvalid, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awaddr, awburst, awlen, awsize, awvalid,
    input  wdata, wstrb, wvalid, bready,
    input  araddr, arburst, arlen, arsize, arvalid, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_stream_burst_writer.sv
// Single-burst AXI4 write master. After reset it issues one AW request using
// the length (arg_1) and base address (arg_2) memories, forwards FIFO words
// (arg_0) as W beats, appends one zero-strobe trailing beat, then holds valid.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   arg_3_s_axi       AXI master port (read side and B channel tied off)
//   arg_1_*           length memory; rdata = burst length L, others tied 0
//   arg_2_*           address memory; rdata = base address, others tied 0
//   arg_0_*           FIFO; read_valid pops, out_data valid the cycle after
//   valid             done flag, stays high until reset
module axi_stream_burst_writer (
  input  logic        clk,
  input  logic        rst,
  axi_stream_burst_writer_if.master arg_3_s_axi,
  output logic [7:0]  arg_1_raddr,
  output logic [7:0]  arg_1_waddr,
  output logic [7:0]  arg_1_wdata,
  output logic        arg_1_wen,
  input  logic [7:0]  arg_1_rdata,
  output logic [15:0] arg_2_raddr,
  output logic [15:0] arg_2_waddr,
  output logic [15:0] arg_2_wdata,
  output logic        arg_2_wen,
  input  logic [15:0] arg_2_rdata,
  output logic        arg_0_read_valid,
  output logic [31:0] arg_0_in_data,
  output logic        arg_0_write_valid,
  input  logic [31:0] arg_0_out_data,
  input  logic        arg_0_read_ready,
  input  logic        arg_0_write_ready,
  output logic        valid
);

  typedef enum logic [2:0] {
    S_AW    = 3'd0,
    S_WAIT  = 3'd1,
    S_POP   = 3'd2,
    S_BEAT  = 3'd3,
    S_CHECK = 3'd4,
    S_LWAIT = 3'd5,
    S_LAST  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  // Low for the whole reset interval and high from the first cycle after
  // release; gates every strobe so reset shows as all-idle outputs that
  // come straight from flops.
  logic       run_q;

  // Static / tied-off outputs
  assign arg_3_s_axi.awaddr  = arg_2_rdata;
  assign arg_3_s_axi.awlen   = arg_1_rdata;
  assign arg_3_s_axi.awburst = 2'b01;
  assign arg_3_s_axi.awsize  = 3'b101;
  assign arg_3_s_axi.bready  = 1'b0;
  assign arg_3_s_axi.araddr  = 16'd0;
  assign arg_3_s_axi.arburst = 2'b00;
  assign arg_3_s_axi.arlen   = 8'd0;
  assign arg_3_s_axi.arsize  = 3'b000;
  assign arg_3_s_axi.arvalid = 1'b0;
  assign arg_3_s_axi.rready  = 1'b0;
  assign arg_1_raddr = 8'd0;
  assign arg_1_waddr = 8'd0;
  assign arg_1_wdata = 8'd0;
  assign arg_1_wen   = 1'b0;
  assign arg_2_raddr = 16'd0;
  assign arg_2_waddr = 16'd0;
  assign arg_2_wdata = 16'd0;
  assign arg_2_wen   = 1'b0;
  assign arg_0_in_data     = 32'd0;
  assign arg_0_write_valid = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{arg_3_s_axi.arready, arg_3_s_axi.bvalid,
                           arg_3_s_axi.rvalid, arg_3_s_axi.rdata,
                           arg_0_write_ready};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_AW;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d             = state_q;
    len_d               = len_q;
    cnt_d               = cnt_q;
    arg_3_s_axi.awvalid = 1'b0;
    arg_3_s_axi.wvalid  = 1'b0;
    arg_3_s_axi.wdata   = 32'd0;
    arg_3_s_axi.wstrb   = 4'h0;
    arg_0_read_valid    = 1'b0;
    valid               = 1'b0;
    if (run_q) begin
      unique case (state_q)
        S_AW: begin
          arg_3_s_axi.awvalid = 1'b1;
          if (arg_3_s_axi.awready) begin
            // Length is latched here; later memory changes do not matter.
            len_d   = arg_1_rdata;
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (arg_3_s_axi.wready && arg_0_read_ready) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_POP;
          end
        end
        S_POP: begin
          arg_0_read_valid = 1'b1;
          state_d          = S_BEAT;
        end
        S_BEAT: begin
          // wready was seen in S_WAIT; the slave is trusted to take this beat.
          arg_3_s_axi.wvalid = 1'b1;
          arg_3_s_axi.wdata  = arg_0_out_data;
          arg_3_s_axi.wstrb  = 4'hF;
          state_d            = S_CHECK;
        end
        S_CHECK: begin
          // Signed compare: L <= 0 (incl. 0x80..0xFF) yields a single beat.
          if ($signed(cnt_q) < $signed(len_q)) state_d = S_WAIT;
          else                                 state_d = S_LWAIT;
        end
        S_LWAIT: begin
          if (arg_3_s_axi.wready) state_d = S_LAST;
        end
        S_LAST: begin
          arg_3_s_axi.wvalid = 1'b1;
          state_d            = S_DONE;
        end
        S_DONE: begin
          valid = 1'b1;
        end
        default: state_d = S_AW;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Scoreboard bench for axi_stream_burst_writer: expected W beats are queued
// when a burst is set up and popped as the DUT emits them.
module tb_axi_stream_burst_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_stream_burst_writer_if axi ();

  logic [7:0]  a1_raddr, a1_waddr, a1_wdata;
  logic        a1_wen;
  logic [7:0]  len_mem;
  logic [15:0] a2_raddr, a2_waddr, a2_wdata;
  logic        a2_wen;
  logic [15:0] addr_mem;
  logic        rd_v, wr_v, valid;
  logic [31:0] in_data;
  logic [31:0] out_data = 32'd0;
  logic        rr = 1'b0;
  logic        fifo_en = 1'b1;

  axi_stream_burst_writer dut (
    .clk(clk), .rst(rst), .arg_3_s_axi(axi),
    .arg_1_raddr(a1_raddr), .arg_1_waddr(a1_waddr), .arg_1_wdata(a1_wdata),
    .arg_1_wen(a1_wen), .arg_1_rdata(len_mem),
    .arg_2_raddr(a2_raddr), .arg_2_waddr(a2_waddr), .arg_2_wdata(a2_wdata),
    .arg_2_wen(a2_wen), .arg_2_rdata(addr_mem),
    .arg_0_read_valid(rd_v), .arg_0_in_data(in_data),
    .arg_0_write_valid(wr_v), .arg_0_out_data(out_data),
    .arg_0_read_ready(rr), .arg_0_write_ready(1'b1),
    .valid(valid)
  );

  logic [31:0] fifo[$];
  logic [35:0] exp_q[$];
  logic [35:0] e;
  int total = 0, bad = 0, rd_cnt = 0, beats_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor + FIFO model: data popped in the S_POP cycle is presented the next.
  always @(negedge clk) begin
    if (axi.wvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'(axi.wvalid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("wdata", 64'(axi.wdata), 64'(e[35:4]));
        chk("wstrb", 64'(axi.wstrb), 64'(e[3:0]));
        beats_seen++;
      end
    end
    if (rd_v === 1'b1) begin
      rd_cnt++;
      if (fifo.size() > 0) out_data = fifo.pop_front();
    end
    if (fifo_en == 1'b0) chk("stall_quiet", 64'({rd_v, axi.wvalid}), 64'd0);
    rr = fifo_en && (fifo.size() != 0);
  end

  task automatic do_reset();
    rst = 1'b0;
    fifo_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_outs", 64'({axi.awvalid, axi.wvalid, rd_v, valid, axi.wstrb}), 64'd0);
    @(posedge clk); #1;
    chk("reset_wdata", 64'({axi.wdata, axi.bready, wr_v, a1_wen, a2_wen}), 64'd0);
    fifo.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs one burst; entered just before the reset-release edge.
  task automatic run_body(input logic [7:0] L, input logic [15:0] addr,
                          input int aw_stall, input int stall);
    int n, cyc, aw_cyc, exp_cyc, stall_left;
    bit done;
    logic [31:0] w;
    n = ($signed(L) > 0) ? int'(L) : 1;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo.push_back(w);
      exp_q.push_back({w, 4'hF});
    end
    exp_q.push_back({32'h0, 4'h0});
    len_mem = L; addr_mem = addr;
    axi.awready = (aw_stall == 0);
    axi.wready = 1'b1;
    fifo_en = 1'b1;
    rd_cnt = 0; beats_seen = 0; aw_cyc = 0; stall_left = stall;
    exp_cyc = 1 + 4 * n + 2 + aw_stall + ((stall > 0) ? stall - 1 : 0);
    cyc = 0; done = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      axi.awready = (cyc >= aw_stall);
      if (axi.awvalid) begin
        if (aw_cyc == 0) begin
          chk("awaddr", 64'(axi.awaddr), 64'(addr));
          chk("awlen", 64'(axi.awlen), 64'(L));
          chk("awburst_size", 64'({axi.awburst, axi.awsize}), 64'({2'b01, 3'b101}));
        end
        aw_cyc++;
      end else if (aw_cyc > 0) len_mem = L ^ 8'h02;
      if (stall_left > 0 && beats_seen == 1) begin
        fifo_en = 1'b0;
        stall_left--;
      end else fifo_en = 1'b1;
      if (valid) done = 1;
      else cyc++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_cyc));
    chk("aw_cycles", 64'(aw_cyc), 64'(aw_stall + 1));
    chk("pops", 64'(rd_cnt), 64'(n));
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("valid_hold", 64'({valid, axi.awvalid, rd_v, axi.wvalid}), 64'b1000);
    end
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0;
    len_mem = 8'd0; addr_mem = 16'd0;

    do_reset(); run_body(8'd3,   16'h1234, 0, 0);
    do_reset(); run_body(8'd0,   16'h0040, 0, 0);
    do_reset(); run_body(8'h80,  16'hBEEF, 0, 0);
    do_reset(); run_body(8'd3,   16'h0100, 5, 0);
    do_reset(); run_body(8'd2,   16'h0200, 0, 10);
    do_reset(); run_body(8'd127, 16'hFFF0, 0, 0);

    // Reset during the second data beat, then a fresh burst without re-setup.
    do_reset();
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    fifo.push_back(w0); fifo.push_back(w1); fifo.push_back(w2);
    exp_q.push_back({w0, 4'hF}); exp_q.push_back({w1, 4'hF});
    len_mem = 8'd3; addr_mem = 16'h00A0;
    axi.awready = 1'b1; axi.wready = 1'b1; beats_seen = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_beat2", 64'(axi.wvalid), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_quiet", 64'({axi.awvalid, axi.wvalid, axi.wstrb, rd_v, valid}), 64'd0);
    chk("abort_wdata", 64'(axi.wdata), 64'd0);
    chk("abort_beats", 64'(beats_seen), 64'd2);
    chk("abort_fifo", 64'(fifo.size()), 64'd1);
    fifo.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_body(8'd3, 16'h00A0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
